// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_sub_step.sv
// One restoring trial subtraction: a + ~b + 1 over WIDTH+1 bits.
module div_sub_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] sum;

    // The caller keeps a < 2*b, so the sign bit of the truncated sum is the borrow.
    assign sum    = a + ~b + {{WIDTH{1'b0}}, 1'b1};
    assign diff   = sum[WIDTH-1:0];
    assign borrow = sum[WIDTH];

endmodule

// File: rtl/div32_restoring.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Define DIV32_SIGNED_EN to add the signed_op input for truncating signed division.
module div32_restoring
    import div_pkg::*;
#(
    parameter  int unsigned WIDTH = DIV_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state, state_n;
    logic [WIDTH-1:0] rem_r, q_r, dvsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             neg_q_r, neg_r_r;

    logic             sgn_dd, sgn_dv;
    logic [WIDTH-1:0] mag_dd, mag_dv;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_next, q_next;

`ifdef DIV32_SIGNED_EN
    assign sgn_dd = signed_op & dividend[WIDTH-1];
    assign sgn_dv = signed_op & divisor[WIDTH-1];
`else
    assign sgn_dd = 1'b0;
    assign sgn_dv = 1'b0;
`endif
    assign mag_dd = sgn_dd ? (~dividend + 1'b1) : dividend;
    assign mag_dv = sgn_dv ? (~divisor + 1'b1) : divisor;

    // The bit shifted out of rem is kept as the trial's top bit so large divisors stay exact.
    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .a      ({rem_r, q_r[WIDTH-1]}),
        .b      ({1'b0, dvsr_r}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign rem_next = borrow ? {rem_r[WIDTH-2:0], q_r[WIDTH-1]} : diff;
    assign q_next   = {q_r[WIDTH-2:0], ~borrow};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (divisor == '0) ? DONE : CALC;
            CALC:    if (cnt_r == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r       <= '0;
            q_r         <= '0;
            dvsr_r      <= '0;
            cnt_r       <= '0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_r   <= '0;
                        q_r     <= mag_dd;
                        dvsr_r  <= mag_dv;
                        cnt_r   <= CNT_W'(WIDTH - 1);
                        neg_q_r <= sgn_dd ^ sgn_dv;
                        neg_r_r <= sgn_dd;
                        if (divisor == '0) begin
                            quotient    <= {WIDTH{DIV0_QUOTIENT[0]}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_next;
                    q_r   <= q_next;
                    if (cnt_r == '0) begin
                        quotient    <= neg_q_r ? (~q_next + 1'b1) : q_next;
                        remainder   <= neg_r_r ? (~rem_next + 1'b1) : rem_next;
                        div_by_zero <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
